// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and types for the 8-channel TDM demultiplexer.
// Build option: TDM_DEMUX_PARITY_EN adds a ninth (even-parity) slot per frame.
package tdm_pkg;
   localparam int NUM_CH = 8;
`ifdef TDM_DEMUX_PARITY_EN
   localparam int FRAME_SLOTS = 9;
`else
   localparam int FRAME_SLOTS = 8;
`endif
   localparam int SLOT_W    = 4;
   // Shadow holds every slot except the last, which goes straight to dout.
   localparam int SHADOW_W  = FRAME_SLOTS - 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_SLOTS - 1);

   typedef enum logic {
      HUNT  = 1'b0,
      TRACK = 1'b1
   } tdm_state_e;
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot position counter for the TDM demultiplexer.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   i_clr       force count to 0 (highest priority)
//   i_load1     load 1 (the sync sample has just been taken as slot 0)
//   i_inc       advance one slot, wrapping after LAST_SLOT
//   o_cnt       current slot index (drives ch_sel)
// Build option: TDM_DEMUX_PARITY_EN (via tdm_pkg) sets the wrap point.
module tdm_slot_counter
   import tdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_load1,
   input  logic              i_inc,
   output logic [SLOT_W-1:0] o_cnt
);

   logic [SLOT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_load1) begin
         r_cnt <= SLOT_W'(1);
      end else if (i_inc) begin
         r_cnt <= (r_cnt == LAST_SLOT) ? '0 : r_cnt + SLOT_W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/tdm_demultiplexer_8ch.sv
// tdm_demultiplexer_8ch: recovers eight single-bit channels from a TDM serial
// stream. Locks on a slot-0 sync, tracks slot position, and presents each
// complete frame as a registered byte with a one-cycle valid strobe.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   din, sync    serial sample and slot-0 marker, consumed only when en=1
//   en           sample strobe
//   dout         last complete frame, bit k = channel k
//   frame_valid  one-cycle pulse when dout updates
//   ch_sel       slot the next accepted sample lands in
//   locked       high while tracking
//   parity_err   only with TDM_DEMUX_PARITY_EN: even-parity error of last frame
// Build option: TDM_DEMUX_PARITY_EN (9-slot frame with trailing parity bit).
//
// state | meaning
// HUNT  | waiting for a sample with sync=1; all other samples ignored
// TRACK | aligned; collecting slots, checking sync at slot 0
module tdm_demultiplexer_8ch
   import tdm_pkg::*;
#(
   parameter int SYNC_LOSS_LIMIT = 2
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din,
   input  logic              sync,
   input  logic              en,
   output logic [NUM_CH-1:0] dout,
   output logic              frame_valid,
   output logic [SLOT_W-1:0] ch_sel,
   output logic              locked
`ifdef TDM_DEMUX_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   tdm_state_e          r_state;
   logic [2:0]          r_miss;
   logic [SHADOW_W-1:0] r_shadow;
   logic [NUM_CH-1:0]   r_dout;
   logic                r_fv;
`ifdef TDM_DEMUX_PARITY_EN
   logic                r_perr;
`endif

   logic [SLOT_W-1:0] w_ch;
   logic              w_track;
   logic              w_slot0;
   logic              w_check;
   logic              w_miss_event;
   logic [3:0]        w_miss_inc;
   logic              w_drop;
   logic              w_last;
   logic              w_clr;
   logic              w_load1;
   logic              w_inc;

   assign w_track      = (r_state == TRACK);
   assign w_slot0      = (w_ch == '0);
   assign w_last       = (w_ch == LAST_SLOT);
   // Slot 0 and any early sync both resolve as a sync check.
   assign w_check      = w_slot0 | sync;
   // A check is good only when sync lines up with slot 0.
   assign w_miss_event = w_check & ~(w_slot0 & sync);
   assign w_miss_inc   = {1'b0, r_miss} + 4'd1;
   assign w_drop       = w_miss_event & (w_miss_inc >= 4'(SYNC_LOSS_LIMIT));

   assign w_clr   = en & w_track & w_drop;
   assign w_load1 = en & sync & ~w_clr;
   assign w_inc   = en & w_track & ~sync;

   tdm_slot_counter u_slot_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_clr),
      .i_load1 (w_load1),
      .i_inc   (w_inc),
      .o_cnt   (w_ch)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= HUNT;
         r_miss   <= '0;
         r_shadow <= '0;
         r_dout   <= '0;
         r_fv     <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
         r_perr   <= 1'b0;
`endif
      end else begin
         r_fv <= 1'b0;
         if (en) begin
            if (!w_track) begin
               if (sync) begin
                  r_shadow[0] <= din;
                  r_miss      <= '0;
                  r_state     <= TRACK;
               end
            end else if (w_check) begin
               if (w_drop) begin
                  r_state <= HUNT;
               end else begin
                  r_shadow[0] <= din;
                  r_miss      <= w_miss_event ? w_miss_inc[2:0] : 3'd0;
               end
            end else if (w_last) begin
`ifdef TDM_DEMUX_PARITY_EN
               r_dout <= r_shadow;
               r_perr <= (^r_shadow) ^ din;
`else
               r_dout <= {din, r_shadow};
`endif
               r_fv   <= 1'b1;
            end else begin
               r_shadow[w_ch[2:0]] <= din;
            end
         end
      end
   end

   assign dout        = r_dout;
   assign frame_valid = r_fv;
   assign ch_sel      = w_ch;
   assign locked      = w_track;
`ifdef TDM_DEMUX_PARITY_EN
   assign parity_err  = r_perr;
`endif

endmodule

// File: tb/tb_tdm_demultiplexer_8ch.sv
// Self-checking bench for tdm_demultiplexer_8ch: directed scenarios plus
// randomized traffic against a frame-level reference model and scoreboard.
module tb_tdm_demultiplexer_8ch;

`ifdef TDM_DEMUX_PARITY_EN
   localparam int SLOTS = 9;
`else
   localparam int SLOTS = 8;
`endif
   localparam int LIMIT = 2;

   logic       clk;
   logic       rst_n;
   logic       din;
   logic       sync;
   logic       en;
   logic [7:0] dout;
   logic       frame_valid;
   logic [3:0] ch_sel;
   logic       locked;
`ifdef TDM_DEMUX_PARITY_EN
   logic       parity_err;
`endif

   tdm_demultiplexer_8ch #(.SYNC_LOSS_LIMIT(LIMIT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .sync        (sync),
      .en          (en),
      .dout        (dout),
      .frame_valid (frame_valid),
      .ch_sel      (ch_sel),
      .locked      (locked)
`ifdef TDM_DEMUX_PARITY_EN
      ,
      .parity_err  (parity_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: the frame in progress is the list of samples
   // collected since alignment; its length is the expected slot index.
   bit         m_locked;
   bit         m_bits[$];
   int         m_miss;
   logic [7:0] m_dout;
   bit         m_perr;
   bit         m_fv;
   logic [8:0] sb_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic m_reset();
      m_locked = 0;
      m_bits.delete();
      m_miss = 0;
      m_dout = '0;
      m_perr = 0;
      m_fv   = 0;
      sb_q.delete();
   endtask

   task automatic m_step(input bit e, input bit d, input bit s);
      logic [7:0] w;
      bit         p;
      m_fv = 0;
      if (!e) return;
      if (!m_locked) begin
         if (s) begin
            m_locked = 1;
            m_miss   = 0;
            m_bits.delete();
            m_bits.push_back(d);
         end
         return;
      end
      if (m_bits.size() == 0 || s) begin
         if (m_bits.size() == 0 && s) m_miss = 0;
         else m_miss++;
         m_bits.delete();
         if (m_miss >= LIMIT) m_locked = 0;
         else m_bits.push_back(d);
         return;
      end
      m_bits.push_back(d);
      if (m_bits.size() == SLOTS) begin
         p = 0;
         for (int k = 0; k < 8; k++) w[k] = m_bits[k];
         foreach (m_bits[i]) p ^= m_bits[i];
         m_dout = w;
         m_perr = p;
         m_fv   = 1;
         sb_q.push_back({p, w});
         m_bits.delete();
      end
   endtask

   // One clock of stimulus; inputs change at the falling edge, model
   // advances alongside, and cycle-level outputs are checked a cycle later.
   task automatic cyc(input bit e, input bit d, input bit s);
      int exp_ch;
      en = e; din = d; sync = s;
      m_step(e, d, s);
      @(negedge clk);
      exp_ch = m_locked ? m_bits.size() : 0;
      chk("ch_sel", 32'(ch_sel), 32'(exp_ch));
      chk("locked", 32'(locked), 32'(m_locked));
      chk("frame_valid", 32'(frame_valid), 32'(m_fv));
      chk("dout_hold", 32'(dout), 32'(m_dout));
`ifdef TDM_DEMUX_PARITY_EN
      chk("parity_hold", 32'(parity_err), 32'(m_perr));
`endif
   endtask

   task automatic tx_frame(input logic [7:0] data, input bit s0, input int gap, input bit pflip);
      bit b;
      for (int k = 0; k < SLOTS; k++) begin
         b = (k < 8) ? data[k] : ((^data) ^ pflip);
         cyc(1'b1, b, (k == 0) && s0);
         for (int g = 0; g < gap; g++) cyc(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
   endtask

   task automatic do_reset();
      en = 0; din = 0; sync = 0;
      rst_n = 1'b0;
      #1;
      chk("rst_dout", 32'(dout), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      chk("rst_ch_sel", 32'(ch_sel), 32'h0);
      chk("rst_fv", 32'(frame_valid), 32'h0);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Scoreboard monitor: every presented frame must match the oldest expectation.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && frame_valid) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               $display("FAIL sb_unexpected: got frame %0h expected none at %0t", dout, $time);
            end else begin
               e = sb_q.pop_front();
               chk("sb_dout", 32'(dout), 32'(e[7:0]));
`ifdef TDM_DEMUX_PARITY_EN
               chk("sb_parity", 32'(parity_err), 32'(e[8]));
`endif
            end
         end
      end
   end

   initial begin
      int  tx_slot;
      bit  s;
      rst_n = 1'b1; en = 0; din = 0; sync = 0;
      m_reset();
      @(negedge clk);
      do_reset();
      cyc(0, 0, 0);
      cyc(0, 1, 1);

      // Lock and capture at full rate.
      tx_frame(8'h4D, 1, 0, 0);
      chk("t1_dout", 32'(dout), 32'h4D);
      chk("t1_locked", 32'(locked), 32'h1);
      cyc(0, 0, 0);

      // Gapped strobe.
      do_reset();
      tx_frame(8'h4D, 1, 1, 0);
      chk("t2_dout", 32'(dout), 32'h4D);

      // Sync loss: second bad slot-0 check drops lock.
      do_reset();
      tx_frame(8'hA5, 1, 0, 0);
      tx_frame(8'h3C, 0, 0, 0);
      chk("t3_dout", 32'(dout), 32'h3C);
      tx_frame(8'h81, 0, 0, 0);
      chk("t3_locked", 32'(locked), 32'h0);
      chk("t3_ch_sel", 32'(ch_sel), 32'h0);

      // Early sync at slot 3 realigns.
      do_reset();
      tx_frame(8'h4D, 1, 0, 0);
      cyc(1, 1, 1);
      cyc(1, 0, 0);
      cyc(1, 1, 0);
      chk("t4_ch_pre", 32'(ch_sel), 32'h3);
      cyc(1, 1, 1);
      chk("t4_ch_post", 32'(ch_sel), 32'h1);
      for (int k = 1; k < SLOTS; k++) cyc(1, (k < 8) ? 1'(8'hC3 >> k) : 1'(^8'hC3), 0);
      chk("t4_dout", 32'(dout), 32'hC3);

`ifdef TDM_DEMUX_PARITY_EN
      tx_frame(8'h4D, 1, 0, 0);
      chk("t5_perr0", 32'(parity_err), 32'h0);
      tx_frame(8'h4D, 1, 0, 1);
      chk("t5_perr1", 32'(parity_err), 32'h1);
      cyc(0, 0, 0);
      chk("t5_perr_hold", 32'(parity_err), 32'h1);
`endif

      // Reset mid-frame, then clean re-lock.
      tx_frame(8'h5A, 1, 0, 0);
      for (int k = 0; k < 5; k++) cyc(1, 1, k == 0);
      chk("t6_ch_pre", 32'(ch_sel), 32'h5);
      do_reset();
      tx_frame(8'hE7, 1, 0, 0);
      chk("t6_dout", 32'(dout), 32'hE7);

      // Randomized traffic: gaps, dropped/spurious syncs, slot slips, resets.
      tx_slot = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(999) == 0) begin
            do_reset();
         end else if ($urandom_range(3) == 0) begin
            cyc(0, 1'($urandom_range(1)), 1'($urandom_range(1)));
         end else begin
            if ($urandom_range(63) == 0) tx_slot = (tx_slot + 1) % SLOTS;
            s = (tx_slot == 0);
            if ($urandom_range(15) == 0) s = !s;
            cyc(1, 1'($urandom_range(1)), s);
            tx_slot = (tx_slot + 1) % SLOTS;
         end
      end
      cyc(0, 0, 0);
      chk("sb_drain", 32'(sb_q.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
